// File: rtl/burst_memory_responder.sv
// Memory-side responder for the 4-beat x 64-bit line burst protocol, backed by a line array.
// Optional macro BURST_GAP_EN inserts one idle BURST cycle between beat 1 and beat 2.
module burst_memory_responder #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [63:0] burst_i,
    output logic [63:0] burst_o,
    output logic        resp_o
);

    localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LatLast = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StBurst,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              op_write_q, op_write_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [3:0]        lat_q, lat_d;
    logic [1:0]        beat_q, beat_d;
    logic              gap_q, gap_d;
    logic [255:0]      wr_buf_q, wr_buf_d;
    logic [255:0]      rd_buf_q;
    logic              load_rd;
    logic              commit;
    logic [IdxW-1:0]   req_idx;

    logic [255:0]      mem [DEPTH];

    // Upper address bits alias modulo DEPTH; the low five select bytes within a line.
    assign req_idx = address_i[5 +: IdxW];

    logic unused_addr;
    assign unused_addr = ^{address_i[31:5+IdxW], address_i[4:0]};

    always_comb begin
        state_d    = state_q;
        op_write_d = op_write_q;
        idx_d      = idx_q;
        lat_d      = lat_q;
        beat_d     = beat_q;
        gap_d      = gap_q;
        wr_buf_d   = wr_buf_q;
        load_rd    = 1'b0;
        commit     = 1'b0;
        resp_o     = 1'b0;
        burst_o    = '0;

        unique case (state_q)
            StIdle: begin
                if (read_i || write_i) begin
                    idx_d      = req_idx;
                    op_write_d = !read_i;
                    load_rd    = read_i;
                    lat_d      = '0;
                    beat_d     = '0;
                    gap_d      = 1'b0;
                    if (LATENCY > 0) begin
                        state_d = StWait;
                    end else begin
                        state_d = StBurst;
                    end
                end
            end

            StWait: begin
                if (lat_q == LatLast) begin
                    state_d = StBurst;
                    beat_d  = '0;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end

            StBurst: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    resp_o = 1'b1;
                    if (op_write_q) begin
                        wr_buf_d[{beat_q, 6'd0} +: 64] = burst_i;
                    end else begin
                        burst_o = rd_buf_q[{beat_q, 6'd0} +: 64];
                    end
                    beat_d = beat_q + 2'd1;
`ifdef BURST_GAP_EN
                    if (beat_q == 2'd1) begin
                        gap_d = 1'b1;
                    end
`endif
                    if (beat_q == 2'd3) begin
                        state_d = StDone;
                        commit  = op_write_q;
                    end
                end
            end

            StDone: begin
                if (!read_i && !write_i) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            lat_q      <= '0;
            beat_q     <= '0;
            gap_q      <= 1'b0;
            wr_buf_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            idx_q      <= idx_d;
            lat_q      <= lat_d;
            beat_q     <= beat_d;
            gap_q      <= gap_d;
            wr_buf_q   <= wr_buf_d;
        end
    end

    // Line storage is never reset; a reset on the final beat edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (load_rd && !rst) begin
            rd_buf_q <= mem[req_idx];
        end
        if (commit && !rst) begin
            mem[idx_q] <= wr_buf_d;
        end
    end

endmodule

// File: tb/tb_burst_memory_responder.sv
// Self-checking bench: table of line transactions plus reset-mid-write sequence, scoreboarded.
module tb_burst_memory_responder;

    localparam int unsigned LAT = 2;
    localparam int unsigned DEP = 16;
`ifdef BURST_GAP_EN
    localparam int unsigned NB = 5;
`else
    localparam int unsigned NB = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address_i = '0;
    logic        read_i = 1'b0;
    logic        write_i = 1'b0;
    logic [63:0] burst_i = '0;
    logic [63:0] burst_o;
    logic        resp_o;

    burst_memory_responder #(
        .LATENCY(LAT),
        .DEPTH  (DEP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .burst_i  (burst_i),
        .burst_o  (burst_o),
        .resp_o   (resp_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
        int           hold;
    } txn_t;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [255:0] model [DEP];
    logic [63:0]  exp_q [$];
    txn_t         tbl [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit exp_resp(input int c);
        int o;
        o = c - int'(LAT + 1);
`ifdef BURST_GAP_EN
        return (o == 0) || (o == 1) || (o == 3) || (o == 4);
`else
        return (o >= 0) && (o <= 3);
`endif
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[8:5]);
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns in the same phase, idle again.
    task automatic run_txn(input txn_t t, input string tag);
        int          beats;
        logic [63:0] e;
        beats     = 0;
        address_i = t.addr;
        read_i    = t.rd;
        write_i   = t.wr;
        burst_i   = '0;
        if (t.rd) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(model[idx_of(t.addr)][64*k +: 64]);
        end
        @(posedge clk); #1;
        for (int c = 1; c <= int'(LAT + NB); c++) begin
            if (exp_resp(c)) begin
                check({tag, "_resp"}, {63'd0, resp_o}, 64'd1);
                if (t.rd) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check({tag, "_rdata"}, burst_o, e);
                    end else begin
                        check({tag, "_sb_empty"}, 64'd0, 64'd1);
                    end
                end else begin
                    check({tag, "_wr_burst_o"}, burst_o, 64'd0);
                    burst_i = t.data[64*beats +: 64];
                end
                beats++;
            end else begin
                check({tag, "_idle_resp"}, {63'd0, resp_o}, 64'd0);
                check({tag, "_idle_burst_o"}, burst_o, 64'd0);
            end
            @(posedge clk); #1;
        end
        for (int h = 0; h < t.hold; h++) begin
            check({tag, "_done_resp"}, {63'd0, resp_o}, 64'd0);
            check({tag, "_done_burst_o"}, burst_o, 64'd0);
            @(posedge clk); #1;
        end
        read_i  = 1'b0;
        write_i = 1'b0;
        burst_i = '0;
        if (t.wr && !t.rd) model[idx_of(t.addr)] = t.data;
        @(posedge clk); #1;
        check({tag, "_after_resp"}, {63'd0, resp_o}, 64'd0);
    endtask

    initial begin
        logic [255:0] rnd;
        for (int k = 0; k < 8; k++) rnd[32*k +: 32] = $urandom;

        tbl[0]  = '{1'b0, 1'b1, 32'h0000_0040,
                    {64'h4444444444444444, 64'h3333333333333333,
                     64'h2222222222222222, 64'h1111111111111111}, 0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0040, '0, 0};
        tbl[2]  = '{1'b0, 1'b1, 32'h0000_0000, {64'd4, 64'd3, 64'd2, 64'd1}, 0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0000_0200, '0, 0};
        tbl[4]  = '{1'b0, 1'b1, 32'h0000_00C0, {4{64'hDEADBEEF00000000}}, 0};
        tbl[5]  = '{1'b1, 1'b1, 32'h0000_00C0, {4{64'h5555555555555555}}, 0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0000_00C0, '0, 0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0000_0040, '0, 3};
        tbl[8]  = '{1'b0, 1'b1, 32'hFFFF_03E0, rnd, 1};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_03FF, '0, 0};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_0080, {32{8'hAA}}, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_resp", {63'd0, resp_o}, 64'd0);
        check("reset_burst_o", burst_o, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("t%0d", i));

        // Reset asserted so that it is sampled on the edge ending beat 1 of a write.
        address_i = 32'h0000_0080;
        write_i   = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= int'(LAT + 2); c++) begin
            if (exp_resp(c)) burst_i = {32{2'b01}};
            check("rstw_resp", {63'd0, resp_o}, {63'd0, exp_resp(c)});
            if (c < int'(LAT + 2)) begin
                @(posedge clk); #1;
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstw_resp_after", {63'd0, resp_o}, 64'd0);
        check("rstw_burst_after", burst_o, 64'd0);
        write_i = 1'b0;
        burst_i = '0;
        rst     = 1'b0;
        @(posedge clk); #1;
        check("rstw_idle_resp", {63'd0, resp_o}, 64'd0);
        run_txn('{1'b1, 1'b0, 32'h0000_0080, '0, 0}, "rstw_read");

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
